shiftreg_serialout: RTL and testbench
=====================================

Name: shiftreg_serialout

Overview:
Parallel-in, serial-out transmitter. It is the sending end of the serial-in shift-register receiver path.
- Accepts an N-bit word through a valid/ready load handshake.
- Shifts the word out MSB-first, one bit per clock, with a serial valid qualifier and a last-bit marker.
- Bit order is chosen so that a serial-in receiver shifting in at the LSB holds the original word after N valid bits.
- Supports gapless back-to-back words.

Parameters:
N, 8, word width in bits; legal range N >= 2.

Ports:
clk  input  1  rising-edge clock, the only clock.
reset  input  1  synchronous, active-high reset.
din  input  N  parallel word to transmit; sampled only on an accepted load.
load_valid  input  1  producer has a word on din.
load_ready  output  1  block can accept a word this cycle.
sout  output  1  serial data bit, MSB-first.
sout_valid  output  1  sout carries a valid data bit this cycle.
sout_last  output  1  high during the final (LSB) bit of a word.
busy  output  1  word in flight; equals sout_valid.

Behaviour:
- Internal state:
  - FSM with two states, IDLE and SHIFT.
  - Shift register q[N-1:0].
  - Bit counter cnt, $clog2(N) bits wide, counting 0..N-1.
- Reset, sampled on the rising clk edge while reset=1:
  - state <= IDLE, q <= 0, cnt <= 0.
  - All outputs are 0 while reset is high, including load_ready (forced 0).
  - Reset mid-word aborts the word immediately. No partial bits follow; the next word starts fresh.
- Accept condition: accept = load_valid && load_ready.
- load_ready is combinational:
  - 1 when state==IDLE.
  - 1 when state==SHIFT && cnt==N-1 (this enables the gapless reload).
  - 0 otherwise, and 0 whenever reset=1.
- IDLE:
  - sout=0, sout_valid=0, sout_last=0.
  - On accept: q <= din, cnt <= 0, state <= SHIFT.
- SHIFT:
  - Outputs: sout = q[N-1], sout_valid = 1, sout_last = (cnt==N-1).
  - If cnt != N-1: q <= {q[N-2:0],1'b0}, cnt <= cnt+1.
  - If cnt == N-1 and accept: q <= din, cnt <= 0, stay in SHIFT. The next word's MSB appears the very next cycle, with no idle bit between words.
  - If cnt == N-1 and no accept: state <= IDLE, q <= 0.
- Latency: the word's MSB appears on sout in the cycle after the accepting edge. The LSB appears N cycles after acceptance. A word occupies exactly N consecutive sout_valid cycles.
- Load attempts while load_ready=0 are ignored. din and load_valid have no effect, and the in-flight word is not corrupted.
- din is not required to be stable after the accepting edge.
- Outputs are glitch-free:
  - sout, sout_valid and sout_last derive only from registered state.
  - load_ready derives from registered state plus reset.
- Throughput: one bit per clock with back-to-back loads, i.e. 100% sout_valid occupancy.

Test Plan:
1. N=8, reset 2 cycles, then load 8'hA5 once.
   - Cycles 1..8 after accept: sout = 1,0,1,0,0,1,0,1 with sout_valid=1.
   - sout_last=1 only on cycle 8.
   - Cycle 9: sout_valid=0, load_ready=1.
2. Back-to-back: load 8'hA5, hold load_valid with din=8'h3C.
   - The second accept occurs on the last-bit cycle of the first word.
   - sout carries 16 contiguous valid bits, 10100101 followed by 00111100.
   - sout_last pulses on bits 8 and 16.
3. Load while busy: accept 8'hF0, then drive load_valid=1 with din=8'h0F on bit cycles 2..7.
   - load_ready=0 on those cycles.
   - Output is exactly 11110000.
   - The second word is accepted only on bit cycle 8.
4. Reset mid-word: accept 8'hFF, assert reset on bit cycle 4.
   - The following cycle has sout=0, sout_valid=0, load_ready=0.
   - After release, load_ready=1 and loading 8'h81 yields 10000001.
5. Loopback: connect sout to a serial-in receiver whose enable is sout_valid, and send 8'hC3.
   - The receiver's parallel output equals 8'hC3 on the cycle after sout_last.
6. Parameter check, N=4: load 4'b1001.
   - Output is 1,0,0,1 with sout_last on the 4th bit.
   - Gapless reload of 4'b0110 follows immediately.

Source files
------------

// File: rtl/shiftreg_serialout.sv
// Parallel-in, serial-out transmitter, MSB-first.
// A word can be reloaded on its last-bit cycle, so words go out with no gap.
module shiftreg_serialout #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         sout_last,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;
  logic          accept;

  assign at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign accept  = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          q_d     = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          q_d   = {q_q[N-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
        end else if (accept) begin
          q_d   = din;
          cnt_d = '0;
        end else begin
          q_d     = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Serial outputs come only from flops; ready also sees reset.
  always_comb begin
    load_ready = !reset && ((state_q == IDLE) || at_last);
    sout       = (state_q == SHIFT) ? q_q[N-1] : 1'b0;
    sout_valid = (state_q == SHIFT);
    sout_last  = at_last;
    busy       = sout_valid;
  end

endmodule

// File: tb/tb_shiftreg_serialout.sv
// Bench for shiftreg_serialout: scoreboarded word table,
// mid-word reset, loopback receiver and an N=4 instance.
module tb_shiftreg_serialout;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] din;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_last;
  logic         busy;

  logic       r4, lv4, rdy4, so4, sv4, sl4, b4;
  logic [3:0] d4;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic b;
    logic last;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [N-1:0] word;
    bit           poke;
    bit           chain;
    logic [N-1:0] exp_rx;
  } vec_t;
  vec_t tbl[6];

  logic [N-1:0] rx;

  shiftreg_serialout #(.N(N)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  shiftreg_serialout #(.N(4)) u_dut4 (
    .clk        (clk),
    .reset      (r4),
    .din        (d4),
    .load_valid (lv4),
    .load_ready (rdy4),
    .sout       (so4),
    .sout_valid (sv4),
    .sout_last  (sl4),
    .busy       (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial-in receiver shifting at the LSB
  always @(posedge clk) begin
    if (sout_valid) rx <= {rx[N-2:0], sout};
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, check ready, model the edge, check outputs.
  task automatic cyc(input logic r, input logic lv, input logic [N-1:0] d);
    logic exp_rdy;
    logic acc;
    sb_t  e;
    reset      = r;
    load_valid = lv;
    din        = d;
    #1;
    exp_rdy = !r && (sbq.size() == 0);
    chk1("load_ready", load_ready, exp_rdy);
    acc = lv && exp_rdy;
    @(posedge clk);
    if (r) begin
      sbq.delete();
    end else if (acc) begin
      for (int i = N - 1; i >= 0; i--) sbq.push_back('{d[i], (i == 0)});
    end
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk1("sout_valid", sout_valid, 1'b1);
      chk1("sout", sout, e.b);
      chk1("sout_last", sout_last, e.last);
      chk1("busy", busy, 1'b1);
    end else begin
      chk1("sout_valid", sout_valid, 1'b0);
      chk1("sout", sout, 1'b0);
      chk1("sout_last", sout_last, 1'b0);
      chk1("busy", busy, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] s4;
    logic [7:0] l4;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{8'hA5, 1'b0, 1'b1, 8'hA5};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C};
    tbl[3] = '{8'hF0, 1'b1, 1'b1, 8'hF0};
    tbl[4] = '{8'h0F, 1'b0, 1'b0, 8'h0F};
    tbl[5] = '{8'hC3, 1'b0, 1'b0, 8'hC3};

    reset      = 1'b1;
    load_valid = 1'b0;
    din        = '0;
    r4         = 1'b1;
    lv4        = 1'b0;
    d4         = '0;
    @(negedge clk);

    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);

    for (int i = 0; i < 6; i++) begin
      if (!(i > 0 && tbl[i-1].chain)) cyc(1'b0, 1'b1, tbl[i].word);
      for (int k = 1; k < N; k++) cyc(1'b0, tbl[i].poke, ~tbl[i].word);
      if (tbl[i].chain && i < 5) cyc(1'b0, 1'b1, tbl[i+1].word);
      else cyc(1'b0, 1'b0, N'($urandom));
      chk8("rx_word", rx, tbl[i].exp_rx);
    end

    // Reset during bit 4 of 8'hFF, held two cycles
    cyc(1'b0, 1'b1, 8'hFF);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 8'h55);
    cyc(1'b1, 1'b1, 8'h55);
    cyc(1'b0, 1'b1, 8'h81);
    for (int k = 1; k < N; k++) cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk8("rx_after_reset", rx, 8'h81);

    // N=4: 1001 then gapless 0110
    s4 = 8'b1001_0110;
    l4 = 8'b0001_0001;
    r4  = 1'b0;
    lv4 = 1'b1;
    d4  = 4'b1001;
    #1;
    chk1("n4_ready_idle", rdy4, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk1("n4_sout", so4, s4[7-k]);
      chk1("n4_valid", sv4, 1'b1);
      chk1("n4_last", sl4, l4[7-k]);
      chk1("n4_ready", rdy4, (k == 3) || (k == 7));
      lv4 = (k == 3);
      d4  = (k == 3) ? 4'b0110 : 4'b1111;
      @(negedge clk);
    end
    chk1("n4_valid_end", sv4, 1'b0);
    chk1("n4_busy_end", b4, 1'b0);
    chk1("n4_ready_end", rdy4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
